alu_op_sequencer: RTL

Initiator side of the arithmetic units' start/done handshake. It accepts one operation request (opcode plus two signed 8-bit operands) on a valid/ready interface. It issues a single-cycle start pulse to the selected arithmetic unit (add, sub, mul, div), waits for that unit's done, and returns the unit's 16-bit result on a valid/ready response interface. A watchdog aborts any operation whose unit never answers.

---
 rtl/alu_op_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Start/done handshake initiator for the add/sub/mul/div units: accepts one request,
// pulses the selected unit's start, waits for done (with a watchdog) and returns the result.
module alu_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int UNIT_COUNT     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [7:0]              req_a,
  input  logic [7:0]              req_b,
  output logic [UNIT_COUNT-1:0]   unit_start,
  output logic [7:0]              unit_a,
  output logic [7:0]              unit_b,
  input  logic [UNIT_COUNT-1:0]   unit_done,
  input  logic [16*UNIT_COUNT-1:0] unit_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_result,
  output logic [1:0]              rsp_op,
  output logic                    rsp_timeout,
  output logic [7:0]              timeout_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [7:0]  wait_cnt;
  logic        done_sel;
  logic [15:0] result_sel;
  logic        last_cnt;

  assign done_sel   = unit_done[op_q];
  assign result_sel = unit_result[{op_q, 4'b0000} +: 16];
  assign last_cnt   = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: default first so every path assigns state_nxt; otherwise a latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid && req_ready) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done_sel || last_cnt) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Start is decoded from the state register, so it is one cycle wide and drops with reset.
  always_comb begin
    unit_start = '0;
    if (state == S_ISSUE) unit_start[op_q] = 1'b1;
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_op    = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b0;
      op_q          <= '0;
      unit_a        <= '0;
      unit_b        <= '0;
      wait_cnt      <= '0;
      rsp_result    <= '0;
      rsp_timeout   <= 1'b0;
      timeout_count <= '0;
    end else begin
      // Registered ready keeps the request side free of input-to-output paths.
      req_ready <= (state_nxt == S_IDLE);
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q   <= req_op;
            unit_a <= req_a;
            unit_b <= req_b;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (done_sel) begin
            rsp_result  <= result_sel;
            rsp_timeout <= 1'b0;
          end else if (last_cnt) begin
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
